// File: rtl/alu_pkg.sv
// Shared types and constants for the 16-bit registered ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor; subtraction is A + ~B + 1.
// Carry and overflow outputs exist only when ALU_FLAGS_EN is defined.
module alu_addsub #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
`ifdef ALU_FLAGS_EN
  output logic             carry_o,
  output logic             overflow_o,
`endif
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;

`ifdef ALU_FLAGS_EN
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{Width{1'b0}}, sub_i};
  // Operands of equal effective sign whose sum flips sign.
  assign overflow_o = (a_i[Width-1] == b_eff[Width-1]) && (sum_o[Width-1] != a_i[Width-1]);
`else
  assign sum_o = a_i + b_eff + {{(Width-1){1'b0}}, sub_i};
`endif

endmodule

// File: rtl/sixtn_bit_arithematic_logic_unit.sv
// Registered 16-bit ALU: one result per accepted op, one cycle later.
// Flag logic is built only when ALU_FLAGS_EN is defined; otherwise flags read 0.
module sixtn_bit_arithematic_logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  alu_op_e          op;
  logic [WIDTH-1:0] as_sum;
  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_q;

  assign op = alu_op_e'(control);

`ifdef ALU_FLAGS_EN
  logic       as_carry;
  logic       as_overflow;
  alu_flags_t flags_d, flags_q;
`endif

  alu_addsub #(
    .Width(WIDTH)
  ) u_addsub (
    .a_i       (A),
    .b_i       (B),
    .sub_i     (op == OP_SUB),
`ifdef ALU_FLAGS_EN
    .carry_o   (as_carry),
    .overflow_o(as_overflow),
`endif
    .sum_o     (as_sum)
  );

  always_comb begin
    result_d = '0;
    unique case (op)
      OP_ADD, OP_SUB: result_d = as_sum;
      OP_AND:         result_d = A & B;
      OP_OR:          result_d = A | B;
      OP_XOR:         result_d = A ^ B;
      OP_NOT:         result_d = ~A;
      OP_SHL:         result_d = {A[WIDTH-2:0], 1'b0};
      OP_SHR:         result_d = {1'b0, A[WIDTH-1:1]};
      default:        result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;

`ifdef ALU_FLAGS_EN
  always_comb begin
    flags_d          = '0;
    flags_d.zero     = (result_d == '0);
    flags_d.negative = result_d[WIDTH-1];
    unique case (op)
      OP_ADD, OP_SUB: begin
        flags_d.carry    = as_carry;
        flags_d.overflow = as_overflow;
      end
      OP_SHL:  flags_d.carry = A[WIDTH-1];
      OP_SHR:  flags_d.carry = A[0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '{zero: 1'b1, carry: 1'b0, overflow: 1'b0, negative: 1'b0};
    end else if (in_valid) begin
      flags_q <= flags_d;
    end
  end

  assign zero     = flags_q.zero;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign negative = flags_q.negative;
`else
  assign zero     = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_sixtn_bit_arithematic_logic_unit.sv
// Directed and random checks of the registered ALU against a scoreboard model.
module tb_sixtn_bit_arithematic_logic_unit;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        c;
    logic        v;
    logic        n;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  control;
  logic [15:0] result;
  logic        out_valid;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        negative;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  exp_t rst_exp;

  sixtn_bit_arithematic_logic_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .control  (control),
    .result   (result),
    .out_valid(out_valid),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .negative (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    e = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[15:0];
        e.c = s[16];
        e.v = (a[15] == b[15]) && (e.r[15] != a[15]);
      end
      3'b001: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = (a[15] != b[15]) && (e.r[15] != a[15]);
      end
      3'b010: e.r = a & b;
      3'b011: e.r = a | b;
      3'b100: e.r = a ^ b;
      3'b101: e.r = ~a;
      3'b110: begin e.r = {a[14:0], 1'b0}; e.c = a[15]; end
      default: begin e.r = {1'b0, a[15:1]}; e.c = a[0]; end
    endcase
    e.z = (e.r == 16'h0);
    e.n = e.r[15];
`ifndef ALU_FLAGS_EN
    e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.n = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e, input logic exp_valid);
    chk({tag, ".valid"}, {15'h0, out_valid}, {15'h0, exp_valid});
    chk({tag, ".result"}, result, e.r);
    chk({tag, ".flags"}, {12'h0, zero, carry, overflow, negative},
        {12'h0, e.z, e.c, e.v, e.n});
  endtask

  // Drive one op, then check the popped expectation one edge later.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic chk_lit, input logic [15:0] lit);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; control = op; A = a; B = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".underflow"}, 16'h1, 16'h0);
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      chk_state(tag, e, 1'b1);
      if (chk_lit) chk({tag, ".lit"}, result, lit);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF; control = 3'b000;
    @(posedge clk);
    #1;
    chk_state(tag, last_exp, 1'b0);
  endtask

  initial begin
    rst_exp = '0;
`ifdef ALU_FLAGS_EN
    rst_exp.z = 1'b1;
`endif
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; control = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", rst_exp, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = rst_exp;
    idle_cycle("idle_after_reset");

    run_op("add_basic", 3'b000, 16'h1234, 16'h5678, 1'b1, 16'h68AC);
    run_op("add_carry", 3'b000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000);
    run_op("add_ovf",   3'b000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000);
    run_op("sub_basic", 3'b001, 16'h5678, 16'h1234, 1'b1, 16'h4444);
    run_op("sub_zero",  3'b001, 16'h0001, 16'h0001, 1'b1, 16'h0000);
    run_op("sub_borrow",3'b001, 16'h0000, 16'h0001, 1'b1, 16'hFFFF);
    run_op("sub_ovf",   3'b001, 16'h8000, 16'h0001, 1'b1, 16'h7FFF);
    run_op("and_zero",  3'b010, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000);
    run_op("or_ones",   3'b011, 16'hAAAA, 16'h5555, 1'b1, 16'hFFFF);
    run_op("xor_ones",  3'b100, 16'hF0F0, 16'h0F0F, 1'b1, 16'hFFFF);
    run_op("and_alt",   3'b010, 16'hAAAA, 16'h5555, 1'b1, 16'h0000);
    run_op("not_a",     3'b101, 16'h00FF, 16'h1234, 1'b1, 16'hFF00);
    run_op("shl",       3'b110, 16'h8001, 16'h0000, 1'b1, 16'h0002);
    run_op("shr",       3'b111, 16'h8001, 16'h0000, 1'b1, 16'h4000);
    idle_cycle("hold1");
    idle_cycle("hold2");

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 3'($urandom_range(7)), 16'($urandom), 16'($urandom), 1'b0, 16'h0);
    end
    idle_cycle("hold_rand");

    // Reset asserted between edges while an op is presented.
    run_op("pre_rst", 3'b011, 16'h1200, 16'h0034, 1'b1, 16'h1234);
    @(negedge clk);
    in_valid = 1'b1; control = 3'b000; A = 16'h1111; B = 16'h2222;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("rst_async", rst_exp, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    last_exp = rst_exp;
    @(posedge clk);
    #1;
    chk_state("rst_discard", rst_exp, 1'b0);
    run_op("post_rst", 3'b000, 16'h0001, 16'h0002, 1'b1, 16'h0003);
    chk("sb_empty", 16'(sb_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sixtn_bit_arithematic_logic_unit.md
# sixtn_bit_arithematic_logic_unit

Registered 16-bit ALU performing add, subtract, bitwise logic and single-bit shifts on two operands selected by a 3-bit opcode. It sits in the datapath execute stage and produces one result and status-flag set per accepted operation, one clock after acceptance. Inputs are sampled on the clock edge; outputs are held stable until the next accepted operation.

## Interface
- WIDTH, 16, operand/result width (bench and flag rules assume 16)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request; sampled every rising clk edge
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- control  input  3  opcode
- result  output  WIDTH  registered result
- out_valid  output  1  result/flags updated this cycle (one-cycle pulse per accepted op)
- zero  output  1  result == 0
- carry  output  1  carry-out (add) / no-borrow (sub) / shifted-out bit (shifts)
- overflow  output  1  signed two's-complement overflow (add/sub only)
- negative  output  1  result[WIDTH-1]

## Operation
- Opcodes: 000 ADD A+B; 001 SUB A−B; 010 AND; 011 OR; 100 XOR; 101 NOT A (B ignored); 110 SHL A by 1, zero fill; 111 SHR A by 1 (logical), zero fill.
- Arithmetic modulo 2^WIDTH; result truncated to WIDTH bits.
- ADD: carry = bit WIDTH of A+B; overflow = A,B same sign and result sign differs.
- SUB: computed as A + ~B + 1; carry = 1 when A ≥ B unsigned (no borrow); overflow = A,B differ in sign and result sign differs from A.
- Logic ops and NOT: carry = 0, overflow = 0.
- SHL: carry = A[WIDTH-1]; SHR: carry = A[0]; overflow = 0.
- zero and negative derived from the new result for every opcode.
- in_valid = 0: result and flags hold previous values; out_valid = 0.

## Timing
- Latency 1 cycle: op accepted at edge N (in_valid = 1) → result/flags/out_valid visible after edge N; out_valid deasserts after edge N+1 unless another op accepted.
- Back-to-back ops every cycle supported; no backpressure, no stall.
- rst_n low (any time, asynchronous): result = 0, carry = 0, overflow = 0, negative = 0, zero = 1, out_valid = 0. An op in flight when reset asserts is discarded.
- First op accepted on the first rising edge with rst_n high and in_valid = 1.

## Configuration
- ALU_FLAGS_EN defined: carry, overflow, negative, zero computed and registered as above.
- ALU_FLAGS_EN undefined: flag ports remain present but are tied to 0 (zero included); flag logic and registers not synthesized. result and out_valid unaffected.

## Structure
- Package alu_pkg: typedef enum logic [2:0] alu_op_e (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR), ALU_WIDTH = 16 constant, flag struct alu_flags_t {zero, carry, overflow, negative}.
- One sub-module alu_addsub: combinational WIDTH-bit adder/subtractor (sub select input) returning sum, carry, overflow; top instantiates it, muxes by opcode and owns all registers.

## Test plan
- ADD 1234+5678 → result 68AC, carry 0, overflow 0, zero 0; ADD FFFF+0001 → 0000, carry 1, zero 1; ADD 7FFF+0001 → 8000, overflow 1, negative 1.
- SUB 5678−1234 → 4444, carry 1; SUB 0001−0001 → 0000, zero 1, carry 1; SUB 0000−0001 → FFFF, carry 0, negative 1.
- AND F0F0&0F0F → 0000, zero 1; OR AAAA|5555 → FFFF, negative 1; XOR F0F0^0F0F → FFFF; AND AAAA&5555 → 0000.
- NOT A=00FF → FF00; SHL 8001 → 0002, carry 1; SHR 8001 → 4000, carry 1.
- Latency/hold: ops on consecutive cycles each appear exactly one cycle later with out_valid high; idle cycle (in_valid 0) → out_valid 0, result unchanged.
- Reset asserted mid-stream between edges → outputs immediately 0, zero 1, out_valid 0; pending op not produced after release.
